// File: rtl/csr_file.sv
// rtl/csr_file.sv - CSR file: writable tohost with W-stage bypass, optional cycle/instret counters (CSR_COUNTERS_EN)
module csr_file #(
   parameter logic [11:0] TOHOST_ADDR  = 12'h51E,
   parameter logic [31:0] TOHOST_RESET = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  csr_sel_W,
   input  logic [11:0] csr_addr_W,
   input  logic [31:0] rs1_data_W,
   input  logic [4:0]  zimm_W,
   input  logic        inst_valid_W,
   input  logic        stall,
   input  logic [11:0] csr_raddr,
   output logic [31:0] csr_rdata,
   output logic [31:0] tohost,
   output logic        tohost_wr
);

   logic        we;
   logic [31:0] wdata;
   logic [31:0] tohost_d, tohost_q;
   logic        tohost_wr_d, tohost_wr_q;

   always_comb begin
      we    = inst_valid_W && !stall
              && ((csr_sel_W == 2'd1) || (csr_sel_W == 2'd2))
              && (csr_addr_W == TOHOST_ADDR);
      wdata = (csr_sel_W == 2'd1) ? rs1_data_W : {27'b0, zimm_W};
   end

   always_comb begin
      tohost_d    = tohost_q;
      tohost_wr_d = we;
      if (we) begin
         tohost_d = wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tohost_q    <= TOHOST_RESET;
         tohost_wr_q <= 1'b0;
      end else begin
         tohost_q    <= tohost_d;
         tohost_wr_q <= tohost_wr_d;
      end
   end

   assign tohost    = tohost_q;
   assign tohost_wr = tohost_wr_q;

`ifdef CSR_COUNTERS_EN
   logic [63:0] cycle_d, cycle_q;
   logic [63:0] instret_d, instret_q;

   always_comb begin
      cycle_d   = cycle_q + 64'd1;
      instret_d = instret_q;
      if (inst_valid_W && !stall) begin
         instret_d = instret_q + 64'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_q   <= 64'd0;
         instret_q <= 64'd0;
      end else begin
         cycle_q   <= cycle_d;
         instret_q <= instret_d;
      end
   end
`endif

   // tohost match takes priority so the bypass wins over any counter alias
   always_comb begin
      csr_rdata = 32'd0;
      if (csr_raddr == TOHOST_ADDR) begin
         csr_rdata = we ? wdata : tohost_q;
      end else begin
`ifdef CSR_COUNTERS_EN
         case (csr_raddr)
            12'hC00, 12'hC01: csr_rdata = cycle_q[31:0];
            12'hC80, 12'hC81: csr_rdata = cycle_q[63:32];
            12'hC02:          csr_rdata = instret_q[31:0];
            12'hC82:          csr_rdata = instret_q[63:32];
            default:          csr_rdata = 32'd0;
         endcase
`else
         csr_rdata = 32'd0;
`endif
      end
   end

endmodule

// File: tb/tb_csr_file.sv
// tb/tb_csr_file.sv - scoreboard bench for csr_file; counter checks follow CSR_COUNTERS_EN
module tb_csr_file;

   localparam logic [11:0] TA = 12'h51E;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  csr_sel_W;
   logic [11:0] csr_addr_W;
   logic [31:0] rs1_data_W;
   logic [4:0]  zimm_W;
   logic        inst_valid_W;
   logic        stall;
   logic [11:0] csr_raddr;
   logic [31:0] csr_rdata;
   logic [31:0] tohost;
   logic        tohost_wr;

   always #5 clk = ~clk;

   csr_file #(.TOHOST_ADDR(TA), .TOHOST_RESET(32'h0)) dut (
      .clk          (clk),
      .rst          (rst),
      .csr_sel_W    (csr_sel_W),
      .csr_addr_W   (csr_addr_W),
      .rs1_data_W   (rs1_data_W),
      .zimm_W       (zimm_W),
      .inst_valid_W (inst_valid_W),
      .stall        (stall),
      .csr_raddr    (csr_raddr),
      .csr_rdata    (csr_rdata),
      .tohost       (tohost),
      .tohost_wr    (tohost_wr)
   );

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   logic [31:0] m_tohost;
   logic        m_wr;
   logic [63:0] m_cycle;
   logic [63:0] m_instret;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [11:0] a, input logic w, input logic [31:0] wd);
      if (a == TA) return w ? wd : m_tohost;
`ifdef CSR_COUNTERS_EN
      case (a)
         12'hC00, 12'hC01: return m_cycle[31:0];
         12'hC80, 12'hC81: return m_cycle[63:32];
         12'hC02:          return m_instret[31:0];
         12'hC82:          return m_instret[63:32];
         default:          return 32'd0;
      endcase
`else
      return 32'd0;
`endif
   endfunction

   task automatic pop_check(input logic [31:0] obs);
      exp_t e;
      if (exp_q.size() == 0) begin
         check_val("queue_empty", obs, ~obs);
      end else begin
         e = exp_q.pop_front();
         check_val(e.tag, obs, e.val);
      end
   endtask

   // One W-stage cycle: check combinational read before the edge, registered outputs after it
   task automatic cyc(input logic [1:0] sel, input logic [11:0] addr, input logic [31:0] rs1,
                      input logic [4:0] zimm, input logic valid, input logic stl, input logic [11:0] raddr);
      logic        w;
      logic [31:0] wd;
      @(negedge clk);
      csr_sel_W    = sel;
      csr_addr_W   = addr;
      rs1_data_W   = rs1;
      zimm_W       = zimm;
      inst_valid_W = valid;
      stall        = stl;
      csr_raddr    = raddr;
      w  = valid && !stl && (sel == 2'd1 || sel == 2'd2) && (addr == TA);
      wd = (sel == 2'd1) ? rs1 : {27'b0, zimm};
      exp_q.push_back('{"rdata", model_read(raddr, w, wd)});
      #1;
      pop_check(csr_rdata);
      @(posedge clk);
      if (w) m_tohost = wd;
      m_wr    = w;
      m_cycle = m_cycle + 64'd1;
      if (valid && !stl) m_instret = m_instret + 64'd1;
      exp_q.push_back('{"tohost", m_tohost});
      exp_q.push_back('{"tohost_wr", {31'b0, m_wr}});
      #1;
      pop_check(tohost);
      pop_check({31'b0, tohost_wr});
   endtask

   task automatic model_reset();
      m_tohost  = 32'h0;
      m_wr      = 1'b0;
      m_cycle   = 64'd0;
      m_instret = 64'd0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      csr_sel_W    = 2'd0;
      inst_valid_W = 1'b0;
      stall        = 1'b0;
      csr_raddr    = 12'hC00;
      #2 rst = 1'b1;
      model_reset();
      #1;
      check_val("rst_tohost", tohost, 32'h0);
      check_val("rst_tohost_wr", {31'b0, tohost_wr}, 32'h0);
      check_val("rst_cycle", csr_rdata, 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      rst          = 1'b1;
      csr_sel_W    = 2'd0;
      csr_addr_W   = 12'h0;
      rs1_data_W   = 32'h0;
      zimm_W       = 5'h0;
      inst_valid_W = 1'b0;
      stall        = 1'b0;
      csr_raddr    = 12'h0;
      model_reset();
      repeat (2) @(posedge clk);
      do_reset();

      cyc(2'd1, TA, 32'hDEADBEEF, 5'h0, 1'b1, 1'b0, TA);
      check_val("deadbeef_tohost", tohost, 32'hDEADBEEF);
      check_val("deadbeef_wr", {31'b0, tohost_wr}, 32'h1);
      cyc(2'd0, 12'h0, 32'h0, 5'h0, 1'b0, 1'b0, TA);
      check_val("wr_one_cycle", {31'b0, tohost_wr}, 32'h0);

      cyc(2'd2, TA, 32'hFFFF_FFFF, 5'h1F, 1'b1, 1'b0, TA);
      cyc(2'd1, TA, 32'h1234, 5'h0, 1'b1, 1'b1, TA);
      check_val("stall_tohost", tohost, 32'h1F);
      cyc(2'd1, 12'hC00, 32'h5555_0000, 5'h0, 1'b1, 1'b0, 12'hC00);
      cyc(2'd3, TA, 32'hAAAA_AAAA, 5'h3, 1'b1, 1'b0, TA);
      cyc(2'd1, TA, 32'hBBBB_BBBB, 5'h3, 1'b0, 1'b0, TA);

      for (int i = 0; i < 3; i++) begin
         cyc(2'd1, TA, 32'h1000_0000 + i, 5'h0, 1'b1, 1'b0, TA);
      end
      check_val("b2b_last_wins", tohost, 32'h1000_0002);

      for (int i = 0; i < 24; i++) begin
         logic [11:0] ra;
         case ($urandom_range(0, 5))
            0: ra = TA;
            1: ra = 12'hC00;
            2: ra = 12'hC80;
            3: ra = 12'hC02;
            4: ra = 12'hC82;
            default: ra = 12'h123;
         endcase
         cyc(2'($urandom_range(0, 3)), ($urandom_range(0, 2) != 0) ? TA : 12'hC01,
             $urandom, 5'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0), ra);
      end

      do_reset();
      for (int i = 0; i < 10; i++) begin
         cyc(2'd0, 12'h0, 32'h0, 5'h0, (i < 7), 1'b0, 12'hC01);
      end
      @(negedge clk);
      inst_valid_W = 1'b0;
      csr_raddr    = 12'hC00;
      #1;
`ifdef CSR_COUNTERS_EN
      check_val("cycle_10", csr_rdata, 32'd10);
`else
      check_val("cycle_absent", csr_rdata, 32'd0);
`endif
      csr_raddr = 12'hC02;
      #1;
`ifdef CSR_COUNTERS_EN
      check_val("instret_7", csr_rdata, 32'd7);
`else
      check_val("instret_absent", csr_rdata, 32'd0);
`endif
      csr_raddr = 12'hC82;
      #1;
      check_val("instret_hi", csr_rdata, 32'd0);
      @(posedge clk);
      m_cycle = m_cycle + 64'd1;
      #1;

`ifdef CSR_COUNTERS_EN
      force dut.cycle_q = 64'h0000_0000_FFFF_FFFF;
      #1 release dut.cycle_q;
      m_cycle = 64'h0000_0000_FFFF_FFFF;
      cyc(2'd0, 12'h0, 32'h0, 5'h0, 1'b0, 1'b0, 12'hC00);
      cyc(2'd0, 12'h0, 32'h0, 5'h0, 1'b0, 1'b0, 12'hC80);
      check_val("wrap_hi", csr_rdata, 32'd1);
      csr_raddr = 12'hC00;
      #1;
      check_val("wrap_lo", csr_rdata, 32'd1);
`endif

      cyc(2'd1, TA, 32'hCAFE_F00D, 5'h0, 1'b1, 1'b0, TA);
      @(negedge clk);
      csr_sel_W    = 2'd1;
      csr_addr_W   = TA;
      rs1_data_W   = 32'h7777_7777;
      inst_valid_W = 1'b1;
      stall        = 1'b0;
      csr_raddr    = 12'hC00;
      #2 rst = 1'b1;
      model_reset();
      #1;
      check_val("async_tohost", tohost, 32'h0);
      check_val("async_wr", {31'b0, tohost_wr}, 32'h0);
      check_val("async_cycle", csr_rdata, 32'h0);
      @(posedge clk);
      #1;
      check_val("async_write_lost", tohost, 32'h0);
      rst          = 1'b0;
      inst_valid_W = 1'b0;
      csr_sel_W    = 2'd0;
      cyc(2'd0, 12'h0, 32'h0, 5'h0, 1'b0, 1'b0, 12'hC00);
      cyc(2'd2, TA, 32'h0, 5'h0A, 1'b1, 1'b0, TA);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
